insn_sequencer: RTL
===================

Name: insn_sequencer

Overview:
Top-level instruction sequencer for the multi-cycle control unit. It runs the fetch/decode/execute loop:
- requests an instruction word from memory and latches it;
- decodes the opcode class and drives the one-hot start vector that selects and runs the ALU, branch/jump or load/store sub-FSM;
- waits for that sub-FSM's done, counts retired instructions, then loops.
It also detects illegal opcodes and hung handshakes (watchdog) and reports them as a sticky trap.

Parameters:
TIMEOUT_CYCLES, 64, cycles a fetch or execute may wait for its done before a watchdog trap; minimum 2
RET_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  level; while high in IDLE, begin fetching
halt_req  in  1  level; sampled at instruction retire, returns to IDLE instead of fetching the next
fetch_data  in  32  instruction word from memory, valid when fetch_done=1
fetch_done  in  1  memory completion pulse for the fetch
fetch_start  out  1  one-cycle memory request pulse
insn  out  32  latched instruction, stable from DECODE until the next fetch completes
start  out  3  one-hot sub-FSM select: 001 ALU, 010 branch/jump, 100 load/store; held for the whole of EXEC
exec_done  in  1  done from the selected sub-FSM
busy  out  1  high in every state except IDLE and TRAP
trap  out  1  sticky; high in TRAP
trap_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 exec timeout
retired  out  RET_W  retired-instruction count, wraps modulo 2^RET_W

Behaviour:
Reset (async, reset=1), all immediate:
- state=IDLE, insn=0, start=000, fetch_start=0, busy=0, trap=0, trap_cause=00, retired=0, wd counter=0.
- Reset mid-operation aborts immediately; no partial retire.

States and transitions (registered outputs, Moore):
- IDLE: run=1 -> FETCH_REQ.
- FETCH_REQ: fetch_start=1 for exactly this cycle; -> FETCH_WAIT; wd counter cleared.
- FETCH_WAIT:
  - fetch_done=1 -> insn<=fetch_data, -> DECODE.
  - Otherwise wd counter increments; reaching TIMEOUT_CYCLES-1 -> TRAP, cause 10.
- DECODE (1 cycle): class from insn[6:0].
  - ALU (0110011, 0010011, 0111011, 0011011, 0110111, 0010111) -> start<=001.
  - Branch/jump (1100011, 1101111, 1100111) -> start<=010.
  - Load/store (0000011, 0100011) -> start<=100.
  - Any other opcode, or insn[1:0]!=11 -> TRAP, cause 01, start stays 000.
  - Valid class -> EXEC; wd counter cleared.
- EXEC:
  - start held constant.
  - exec_done=1 -> start<=000, retired<=retired+1; then halt_req=1 -> IDLE, else -> FETCH_REQ.
  - Otherwise wd counter increments; reaching TIMEOUT_CYCLES-1 -> TRAP, cause 11, start<=000.
- TRAP: terminal until reset; run, fetch_done and exec_done are ignored.

Edge cases:
- done and watchdog expiry in the same cycle: done wins, no trap.
- fetch_done outside FETCH_WAIT and exec_done outside EXEC: ignored.
- run deasserting mid-loop has no effect; only halt_req stops the loop, at a retire boundary.
- retired 2^RET_W-1 -> 0 on the next retire; no flag.
- Minimum loop, FETCH_REQ to the next FETCH_REQ: 4 cycles, with fetch_done in the first FETCH_WAIT cycle and exec_done in the first EXEC cycle.

Test Plan:
- Reset, run=1; fetch_done after 2 cycles with 0x00500093 (addi) -> insn=0x00500093, start=001 from the cycle after DECODE; exec_done -> retired=1, new fetch_start pulse next cycle.
- Three fetches returning 0x0000006F (jal), 0x00003083 (ld), 0x00113023 (sd) -> start 010, 100, 100 respectively; retired=3.
- Fetch returns 0xFFFFFFFF -> trap=1, trap_cause=01, start=000, busy=0; later exec_done/run pulses change nothing.
- TIMEOUT_CYCLES=8, fetch_done never asserted -> trap with cause 10 exactly 8 cycles after the fetch_start pulse. Repeat with exec_done withheld -> cause 11, start cleared to 000.
- exec_done coincident with the watchdog expiry cycle -> retire counted, no trap. halt_req=1 at a retire -> IDLE, busy=0, no fetch_start.
- Assert reset mid-EXEC with start=100 -> all outputs zero the same cycle. RET_W=4: 16 retires -> retired wraps to 0.

Source files
------------

// File: rtl/insn_sequencer.sv
// rtl/insn_sequencer.sv - fetch/decode/execute instruction sequencer with watchdog trap
//
// Purpose: runs the fetch -> decode -> execute loop of the multi-cycle control unit,
// selects the ALU, branch/jump or load/store sub-FSM, counts retired instructions
// and raises a sticky trap on an illegal opcode or a hung fetch/exec handshake.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   run, halt_req       loop start (level, in IDLE) and stop at retire boundary
//   fetch_start         one-cycle memory request pulse
//   fetch_data/done     returned instruction word and its completion pulse
//   insn                latched instruction word
//   start, exec_done    one-hot sub-FSM select (held in EXEC) and its done
//   busy, trap          activity and sticky trap status
//   trap_cause          00 none, 01 illegal opcode, 10 fetch timeout, 11 exec timeout
//   retired             retired-instruction count, wraps
module insn_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RET_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic [31:0]      fetch_data,
    input  logic             fetch_done,
    output logic             fetch_start,
    output logic [31:0]      insn,
    output logic [2:0]       start,
    input  logic             exec_done,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [RET_W-1:0] retired
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    // A wait cycle that starts with this count and sees no done would take the
    // counter to TIMEOUT_CYCLES-1, which is the expiry point.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_FETCH   = 2'b10;
    localparam logic [1:0] CAUSE_EXEC    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXEC,
        S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       insn_q, insn_d;
    logic [2:0]        start_q, start_d;
    logic [1:0]        cause_q, cause_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              fetch_start_q, fetch_start_d;
    logic              busy_q, busy_d;
    logic              trap_q, trap_d;
    logic [2:0]        start_sel;

    // Opcode class of the latched word; 000 means illegal. Every legal opcode
    // ends in 2'b11, so a full 7-bit match also rejects compressed encodings.
    always_comb begin
        start_sel = 3'b000;
        case (insn_q[6:0])
            7'b0110011, 7'b0010011, 7'b0111011,
            7'b0011011, 7'b0110111, 7'b0010111: start_sel = 3'b001;
            7'b1100011, 7'b1101111, 7'b1100111: start_sel = 3'b010;
            7'b0000011, 7'b0100011:             start_sel = 3'b100;
            default:                            start_sel = 3'b000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        insn_d    = insn_q;
        start_d   = start_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        wd_d      = wd_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                wd_d    = '0;
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                // done is tested first so it wins over a coincident expiry
                if (fetch_done) begin
                    insn_d  = fetch_data;
                    state_d = S_DECODE;
                end else if (wd_q == WD_LAST) begin
                    cause_d = CAUSE_FETCH;
                    state_d = S_TRAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DECODE: begin
                wd_d = '0;
                if (start_sel != 3'b000) begin
                    start_d = start_sel;
                    state_d = S_EXEC;
                end else begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    start_d   = 3'b000;
                    retired_d = retired_q + 1'b1;
                    state_d   = halt_req ? S_IDLE : S_FETCH_REQ;
                end else if (wd_q == WD_LAST) begin
                    start_d = 3'b000;
                    cause_d = CAUSE_EXEC;
                    state_d = S_TRAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        fetch_start_d = (state_d == S_FETCH_REQ);
        busy_d        = (state_d != S_IDLE) && (state_d != S_TRAP);
        trap_d        = (state_d == S_TRAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            insn_q        <= '0;
            start_q       <= '0;
            cause_q       <= '0;
            retired_q     <= '0;
            wd_q          <= '0;
            fetch_start_q <= 1'b0;
            busy_q        <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            insn_q        <= insn_d;
            start_q       <= start_d;
            cause_q       <= cause_d;
            retired_q     <= retired_d;
            wd_q          <= wd_d;
            fetch_start_q <= fetch_start_d;
            busy_q        <= busy_d;
            trap_q        <= trap_d;
        end
    end

    assign fetch_start = fetch_start_q;
    assign insn        = insn_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;
    assign retired     = retired_q;

endmodule
